// File: rtl/main_mem_responder_pkg.sv
// Shared types and constants for the main-memory responder: word/address widths,
// responder state encodings and the response payload carried down the latency pipe.
package main_mem_responder_pkg;

  localparam int unsigned MEM_WORD_WIDTH    = 32;
  localparam int unsigned MEM_ADDR_WIDTH    = 32;
  localparam int unsigned MEM_DEFAULT_DEPTH = 1024;

  typedef enum logic {
    MEM_ST_INIT = 1'b0,
    MEM_ST_RUN  = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                      valid;
    logic                      err;
    logic [MEM_WORD_WIDTH-1:0] data;
  } mem_resp_t;

  // Full-width compare so that high address bits can never alias into the array.
  function automatic logic addr_in_range(input logic [MEM_ADDR_WIDTH-1:0] addr,
                                         input int unsigned depth);
    return addr < MEM_ADDR_WIDTH'(depth);
  endfunction

endpackage

// File: rtl/main_mem_responder_if.sv
// Request/response bundle for the fetch (p0) and load/store (p1) memory streams.
interface main_mem_responder_if;
  import main_mem_responder_pkg::*;

  logic                      p0_req_valid;
  logic                      p0_req_ready;
  logic [MEM_ADDR_WIDTH-1:0] p0_req_addr;
  logic                      p0_resp_valid;
  logic [MEM_WORD_WIDTH-1:0] p0_resp_data;
  logic                      p0_resp_err;

  logic                      p1_req_valid;
  logic                      p1_req_ready;
  logic                      p1_req_write;
  logic [MEM_ADDR_WIDTH-1:0] p1_req_addr;
  logic [MEM_WORD_WIDTH-1:0] p1_req_wdata;
  logic                      p1_resp_valid;
  logic [MEM_WORD_WIDTH-1:0] p1_resp_data;
  logic                      p1_resp_err;

  modport master (
    output p0_req_valid, p0_req_addr,
    input  p0_req_ready, p0_resp_valid, p0_resp_data, p0_resp_err,
    output p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata,
    input  p1_req_ready, p1_resp_valid, p1_resp_data, p1_resp_err
  );

  modport slave (
    input  p0_req_valid, p0_req_addr,
    output p0_req_ready, p0_resp_valid, p0_resp_data, p0_resp_err,
    input  p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata,
    output p1_req_ready, p1_resp_valid, p1_resp_data, p1_resp_err
  );

endinterface

// File: rtl/mem_resp_delay_line.sv
// Fixed-latency shift register for one response stream; stage 0 loads at the accept edge,
// so the last stage presents the response READ_LATENCY cycles after the request cycle.
module mem_resp_delay_line
  import main_mem_responder_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  mem_resp_t i_stage0,
  output mem_resp_t o_resp
);

  mem_resp_t r_pipe [READ_LATENCY];

  // Idle slots carry all-zero payloads so data/err read 0 whenever valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_stage0.valid ? i_stage0 : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_resp = r_pipe[READ_LATENCY-1];

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: owns the word array, zero-fills it after reset, then serves
// fetch reads (p0) and load/store (p1) with fixed-latency in-order responses.
module main_mem_responder
  import main_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH        = MEM_DEFAULT_DEPTH,
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  main_mem_responder_if.slave  bus
);

  logic [MEM_WORD_WIDTH-1:0] r_mem [DEPTH];
  mem_state_e                r_state;
  logic [ADDR_BITS-1:0]      r_clear_ptr;
  logic                      r_ready;

  logic                 w_p0_acc;
  logic                 w_p1_acc;
  logic                 w_p0_in_range;
  logic                 w_p1_in_range;
  logic                 w_p1_wr;
  logic [ADDR_BITS-1:0] w_p0_idx;
  logic [ADDR_BITS-1:0] w_p1_idx;
  mem_resp_t            w_p0_stage0;
  mem_resp_t            w_p1_stage0;
  mem_resp_t            w_p0_resp;
  mem_resp_t            w_p1_resp;

  assign w_p0_acc      = r_ready & bus.p0_req_valid;
  assign w_p1_acc      = r_ready & bus.p1_req_valid;
  assign w_p0_in_range = addr_in_range(bus.p0_req_addr, DEPTH);
  assign w_p1_in_range = addr_in_range(bus.p1_req_addr, DEPTH);
  assign w_p0_idx      = bus.p0_req_addr[ADDR_BITS-1:0];
  assign w_p1_idx      = bus.p1_req_addr[ADDR_BITS-1:0];
  assign w_p1_wr       = w_p1_acc & bus.p1_req_write & w_p1_in_range;

  // Zero-fill sequencer; ready is only raised once the last word is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= MEM_ST_INIT;
      r_clear_ptr <= '0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        MEM_ST_INIT: begin
          r_clear_ptr <= r_clear_ptr + ADDR_BITS'(1);
          if (r_clear_ptr == ADDR_BITS'(DEPTH - 1)) begin
            r_state <= MEM_ST_RUN;
            r_ready <= 1'b1;
          end
        end
        MEM_ST_RUN: begin
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Array storage; holds no reset so the clear happens word-by-word in INIT.
  always_ff @(posedge clk) begin
    if (r_state == MEM_ST_INIT) begin
      r_mem[r_clear_ptr] <= '0;
    end else if (w_p1_wr) begin
      r_mem[w_p1_idx] <= bus.p1_req_wdata;
    end
  end

  // Stage-0 payloads sample the array before this edge's write: read-before-write.
  always_comb begin
    w_p0_stage0 = '0;
    w_p1_stage0 = '0;
    if (w_p0_acc) begin
      w_p0_stage0.valid = 1'b1;
      w_p0_stage0.err   = !w_p0_in_range;
      if (w_p0_in_range) begin
        w_p0_stage0.data = r_mem[w_p0_idx];
      end
    end
    if (w_p1_acc) begin
      w_p1_stage0.valid = 1'b1;
      w_p1_stage0.err   = !w_p1_in_range;
      if (w_p1_in_range && !bus.p1_req_write) begin
        w_p1_stage0.data = r_mem[w_p1_idx];
      end
    end
  end

  mem_resp_delay_line #(
    .READ_LATENCY (READ_LATENCY)
  ) u_p0_delay (
    .clk      (clk),
    .rst_n    (rst),
    .i_stage0 (w_p0_stage0),
    .o_resp   (w_p0_resp)
  );

  mem_resp_delay_line #(
    .READ_LATENCY (READ_LATENCY)
  ) u_p1_delay (
    .clk      (clk),
    .rst_n    (rst),
    .i_stage0 (w_p1_stage0),
    .o_resp   (w_p1_resp)
  );

  assign bus.p0_req_ready  = r_ready;
  assign bus.p1_req_ready  = r_ready;
  assign bus.p0_resp_valid = w_p0_resp.valid;
  assign bus.p0_resp_err   = w_p0_resp.err;
  assign bus.p0_resp_data  = w_p0_resp.data;
  assign bus.p1_resp_valid = w_p1_resp.valid;
  assign bus.p1_resp_err   = w_p1_resp.err;
  assign bus.p1_resp_data  = w_p1_resp.data;

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Memory-side responder for the CPU's two main-memory access streams.
  - Port 0 serves instruction fetch (read-only).
  - Port 1 serves load/store data (read/write).
- Owns the word-addressed main memory array and clears it to zero after every reset.
- Returns in-order responses at a fixed latency, so the pipeline's fetch and memory stages can be timed statically.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array.
- ADDR_BITS, 10, index width; must equal clog2(DEPTH).
- READ_LATENCY, 2, cycles from request accept to response; legal range 1..4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- p0_req_valid  input  1  fetch request present.
- p0_req_ready  output  1  responder accepts requests this cycle.
- p0_req_addr  input  32  fetch word address.
- p0_resp_valid  output  1  fetch response present (one-cycle pulse).
- p0_resp_data  output  32  fetched word.
- p0_resp_err  output  1  fetch address out of range.
- p1_req_valid  input  1  data request present.
- p1_req_ready  output  1  responder accepts requests this cycle.
- p1_req_write  input  1  1 = store, 0 = load.
- p1_req_addr  input  32  data word address.
- p1_req_wdata  input  32  store data.
- p1_resp_valid  output  1  data response present (one-cycle pulse).
- p1_resp_data  output  32  loaded word; 0 for stores.
- p1_resp_err  output  1  data address out of range.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low; all state clears on the negedge of rst.
- Reset values:
  - state = INIT, clear_ptr = 0.
  - p0_req_ready = p1_req_ready = 0.
  - All resp_valid, resp_data and resp_err outputs = 0.
  - Latency pipelines emptied.
- State INIT:
  - Each cycle, write 0 to word clear_ptr, then increment clear_ptr.
  - When clear_ptr == DEPTH-1 the write completes and the next state is RUN.
  - Both readys are held at 0; requests are ignored, not queued.
- State RUN:
  - Both readys are held at 1. The first RUN cycle is DEPTH cycles after rst deasserts.
  - No exit except reset.
- Handshake:
  - A request is accepted on a rising edge where valid & ready.
  - No backpressure exists on responses; the requester must always sink them.
- Latency:
  - The response for a request accepted at edge N has resp_valid high for the single cycle following edge N+READ_LATENCY-1. That is, the response is visible READ_LATENCY cycles after the request cycle.
  - One request per port per cycle, fully pipelined; responses are returned in acceptance order.
- Range check: an address is in range iff p*_req_addr < DEPTH, compared on all 32 bits (no aliasing).
  - Out-of-range read: resp_data = 0, resp_err = 1.
  - Out-of-range write: dropped (array unchanged), resp_err = 1.
- Writes:
  - Committed to the array at the accept edge.
  - Acknowledged with p1_resp_valid after READ_LATENCY, with p1_resp_data = 0 and err set per the range check.
- Same-cycle hazards:
  - p0 read and p1 write to the same address in the same cycle: p0 returns the old data (read-before-write).
  - Any read accepted on a cycle after a write sees the new data.
- resp_data and resp_err are 0 whenever the matching resp_valid is 0.
- Reset mid-operation: in-flight responses are discarded, outputs return to reset values on the asynchronous assert, and the array is re-cleared in INIT.

Decomposition:
- Shared arch defines include file gains:
  - MEM_WORD_WIDTH (32).
  - MEM_DEFAULT_DEPTH (1024).
  - Responder state encodings MEM_ST_INIT and MEM_ST_RUN.
- Sub-module mem_resp_delay_line:
  - Parameterised READ_LATENCY shift register carrying {valid, err, data[31:0]}, with async active-low reset.
  - Instantiated once per port.
  - Its stage 0 is fed from the array read, the range check and the write flag.

Test Plan (DEPTH=16, READ_LATENCY=2):
1. Release rst, hold p0_req_valid=1 from the first cycle -> readys stay 0 for exactly 16 cycles, no responses; first accept then reads addr 5 -> p0_resp_data=0x0, err=0, two cycles later.
2. p1 write 0xDEADBEEF to addr 3, next cycle p0 read addr 3 -> p1 ack (data 0, err 0) at accept+2; p0 returns 0xDEADBEEF at its accept+2.
3. Same cycle: p0 read addr 7, p1 write 0x12345678 to addr 7 -> p0 returns 0x0; a p0 read of addr 7 on the following cycle returns 0x12345678.
4. p1 read addr 16 -> data 0, err 1. p1 write 0xFFFFFFFF to addr 16 -> err 1. A following read of addr 0 returns 0x0 (no aliasing).
5. Preload words 0..7 with values 0x100+i, then issue p0 reads of addr 0..7 on consecutive cycles -> eight consecutive resp_valid cycles with data 0x100..0x107 in order.
6. Assert rst with two reads in flight -> resp_valid drops to 0 immediately and the reads never return. After release, a previously written address reads 0x0 once RUN is reached.
